// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter that feeds the
// 8-to-3 encoder.
//   N / IW      : request line count and index width
//   req_vec_t   : one bit per request line
//   idx_t       : line index
//   state_t     : arbiter FSM states
//   onehot()    : index -> one-hot vector
//   next_idx()  : index + 1 with wrap at N-1
package arb_pkg;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    typedef logic [N-1:0]  req_vec_t;
    typedef logic [IW-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic req_vec_t onehot(input idx_t i);
        return req_vec_t'(1) << i;
    endfunction

    function automatic idx_t next_idx(input idx_t i);
        idx_t r;
        if (i == idx_t'(N - 1)) r = '0;
        else                    r = i + idx_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/req_rr_arbiter_if.sv
// Request/grant bundle between the request sources, the arbiter and the
// downstream encoder.
//   req_i     : sticky request pulses, one per line
//   ready_i   : downstream accepts the offered grant
//   grant_o   : registered one-hot grant, zero when not valid
//   valid_o   : grant_o holds a grant
//   pending_o : registered pending vector (debug)
//   overrun_o : one-cycle pulse, a request hit an already pending line
// master = arbiter side, slave = sources/downstream side.
interface req_rr_arbiter_if;
    import arb_pkg::*;

    req_vec_t req_i;
    logic     ready_i;
    req_vec_t grant_o;
    logic     valid_o;
    req_vec_t pending_o;
    logic     overrun_o;

    modport master (
        input  req_i, ready_i,
        output grant_o, valid_o, pending_o, overrun_o
    );

    modport slave (
        output req_i, ready_i,
        input  grant_o, valid_o, pending_o, overrun_o
    );

endinterface

// File: rtl/req_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   cand : candidate request vector
//   ptr  : index scanned first
//   sel  : first set bit of cand scanning ptr, ptr+1, ... wrapping mod N
//   any  : cand has at least one bit set (sel is meaningless otherwise)
// Rotating a doubled copy right by ptr puts line ptr at bit 0, so a plain
// lowest-bit priority scan gives the offset from ptr.
module rr_pick
    import arb_pkg::*;
(
    input  req_vec_t cand,
    input  idx_t     ptr,
    output idx_t     sel,
    output logic     any
);

    localparam logic [IW:0] N_W = (IW + 1)'(N);

    req_vec_t    rot;
    idx_t        off;
    logic [IW:0] sum;

    always_comb begin
        rot = req_vec_t'({cand, cand} >> ptr);
        off = '0;
        // Descending scan: the lowest set bit is the last one to write off.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = idx_t'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        sel = (sum >= N_W) ? idx_t'(sum - N_W) : sum[IW-1:0];
        any = |cand;
    end

endmodule

// File: rtl/req_rr_arbiter.sv
// Round-robin request arbiter, upstream of the 8-to-3 encoder.
// Latches request pulses into a pending vector, picks one pending line per
// transaction in round-robin order and offers it as a registered one-hot
// grant with valid/ready. The encoder never sees zero-hot or multi-hot.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/grant bundle (master side)
module req_rr_arbiter
    import arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    req_rr_arbiter_if.master   bus
);

    state_t   state_q, state_d;
    req_vec_t pending_q;
    req_vec_t grant_q, grant_d;
    idx_t     gidx_q, gidx_d;
    idx_t     ptr_q, ptr_d;
    logic     overrun_q;

    logic     xfer;
    req_vec_t clr;
    req_vec_t cand;
    idx_t     scan_ptr;
    idx_t     sel;
    logic     any;

    // The granted line stays pending until its transfer edge; a request on
    // that same edge re-sets it (set wins over clear).
    assign xfer = (state_q == OFFER) && bus.ready_i;
    assign clr  = xfer ? grant_q : '0;
    assign cand = (pending_q & ~clr) | bus.req_i;

    // On a transfer the follow-on grant is picked with the advanced pointer,
    // so a line re-requested on its own transfer edge goes to the back.
    assign scan_ptr = xfer ? next_idx(gidx_q) : ptr_q;

    rr_pick u_pick (
        .cand (cand),
        .ptr  (scan_ptr),
        .sel  (sel),
        .any  (any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = onehot(sel);
                    gidx_d  = sel;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Grant held stable until accepted, whatever arrives meanwhile.
                if (xfer) begin
                    ptr_d = scan_ptr;
                    if (any) begin
                        grant_d = onehot(sel);
                        gidx_d  = sel;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= cand;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            overrun_q <= |(bus.req_i & pending_q & ~clr);
        end
    end

    assign bus.grant_o   = grant_q;
    assign bus.valid_o   = (state_q == OFFER);
    assign bus.pending_o = pending_q;
    assign bus.overrun_o = overrun_q;

endmodule

// File: doc/req_rr_arbiter.md
Name: req_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures sticky request pulses on 8 lines and picks one pending request per transaction, round-robin.
- Presents the winner as a registered, guaranteed one-hot grant with a valid/ready handshake.
- The downstream encoder therefore never sees zero-hot or multi-hot input.

Parameters:
- N, 8, number of request lines; downstream encoder requires 8.
- IW, 3, index width, equal to clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  N  request pulses; any bit high for one cycle marks that line pending.
- grant_o  output  N  one-hot grant, registered; all zeros when valid_o=0.
- valid_o  output  1  grant_o holds a grant.
- ready_i  input  1  downstream accepts; a transfer occurs on an edge where valid_o&ready_i.
- pending_o  output  N  current pending vector, registered, for debug.
- overrun_o  output  1  one-cycle pulse: a req_i bit arrived while that line was already pending or being granted.

Behaviour:
- Reset, asynchronous on rst_n low: pending=0, grant_o=0, valid_o=0, rr pointer ptr=0, overrun_o=0. All outputs stay low until the first clk edge after rst_n rises.
- Pending update every edge:
  - pending <= (pending & ~clr) | req_i
  - clr = grant_o when valid_o&ready_i, else 0.
  - Set wins: a req_i bit equal to the bit being cleared leaves that bit pending.
- Candidate vector cand = (pending & ~clr) | req_i, the same value as next pending.
- Selection: first set bit of cand scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
- State machine, two states:
  - IDLE (valid_o=0): on an edge where cand!=0, load grant_o=onehot(sel), valid_o=1, go to OFFER. Latency is 1 cycle: req_i at edge t gives valid_o high after edge t.
  - OFFER (valid_o=1): grant_o held stable while ready_i=0, even as new requests arrive.
    - On transfer: ptr <= (granted index + 1) mod N.
    - If the post-clear cand!=0, load the next grant on the same edge and stay in OFFER (no bubble).
    - Otherwise grant_o=0, valid_o=0, go to IDLE.
- The granted line stays in pending until its transfer edge, so it cannot be double-issued.
- overrun_o is registered, high for the cycle after an edge where req_i & pending & ~clr != 0. Lost requests are not counted.
- Index wrap: granted index N-1 sets ptr=0.
- Simultaneous requests on all lines: each line is granted exactly once in ptr order before any line repeats.
- Reset mid-offer: grant is abandoned and all pending requests are discarded.
- Invariant checked by the bench: $onehot(grant_o) when valid_o, grant_o==0 otherwise.

Decomposition:
- Shared package arb_pkg holds:
  - constants N=8 and IW=3
  - typedef req_vec_t [N-1:0]
  - typedef idx_t [IW-1:0]
  - state enum {IDLE, OFFER}
- Sub-module rr_pick: purely combinational.
  - Inputs: cand (N), ptr (IW).
  - Outputs: sel (IW), any (1).
  - Implemented as double-width rotate plus priority scan.
- Top holds the pending, pointer, FSM and output registers.

Test Plan:
- Reset release, req_i=0, ready_i=1 for 5 cycles -> valid_o=0, grant_o=00, pending_o=00, overrun_o=0 throughout.
- Single pulse req_i=0x08, ready_i=1 -> next cycle valid_o=1, grant_o=0x08 for one cycle, then IDLE; pending_o returns to 00; ptr=4.
- req_i=0xFF one cycle, ready_i=1, ptr=0 -> grants 0x01,0x02,0x04,...,0x80 on 8 consecutive cycles with no bubble, then valid_o=0.
- Backpressure: req_i=0x24 with ready_i=0 for 4 cycles -> grant_o stays 0x04 stable. After ready_i=1 for 2 cycles -> 0x04 then 0x20 transfer.
- Set-wins and overrun:
  - While grant_o=0x02 is offered with ready_i=0, pulse req_i=0x02 -> overrun_o pulses once.
  - Pulse req_i=0x02 again on the transfer edge -> line 1 remains pending and is granted again after the other pending lines.
- Async reset asserted mid-OFFER (grant_o=0x40, pending 0x41) -> outputs clear immediately without a clock edge. After release, no grant appears until new req_i.
